// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage control: PC register, IF/ID pipeline register and
// hazard/redirect decode, with stall accounting and a sticky stall watchdog.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        CtrlWrite,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic [31:0] Instr_in,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        CtrlBubble,
    output logic [15:0] StallCount,
    output logic        StallTimeout
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned RUN_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [XLEN-1:0]  NOP       = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc_next, instr_next, pc4_next, pc_plus4;
    logic              valid_next, timeout_next;
    logic [CNT_W-1:0]  stall_cnt_next;
    logic [RUN_W-1:0]  hold_run, hold_run_next, hold_run_inc;
    logic              do_hold, do_redirect;

    assign pc_plus4     = PC + XLEN'(4);
    assign do_hold      = PCWrite & IF_IDWrite;
    assign do_redirect  = ~PCWrite & RedirectValid;
    assign hold_run_inc = (hold_run == RUN_LIMIT) ? hold_run : hold_run + RUN_W'(1);

    // Next-state and datapath decode; hold beats a pending redirect.
    always_comb begin
        state_next     = state;
        pc_next        = PC;
        instr_next     = IF_ID_Instr;
        pc4_next       = IF_ID_PC4;
        valid_next     = IF_ID_Valid;
        stall_cnt_next = StallCount;
        hold_run_next  = '0;
        timeout_next   = StallTimeout;

        if (do_redirect) begin
            state_next = SQUASH;
        end else if (do_hold) begin
            state_next = STALL;
        end else begin
            state_next = RUN;
        end

        if (do_hold) begin
            if (StallCount != CNT_MAX) begin
                stall_cnt_next = StallCount + CNT_W'(1);
            end
            hold_run_next = hold_run_inc;
            if (hold_run_inc == RUN_LIMIT) begin
                timeout_next = 1'b1;
            end
        end else if (PCWrite) begin
            instr_next = NOP;
            pc4_next   = '0;
            valid_next = 1'b0;
        end else if (RedirectValid) begin
            pc_next    = {RedirectTarget[31:2], 2'b00};
            instr_next = NOP;
            pc4_next   = '0;
            valid_next = 1'b0;
        end else if (IF_IDWrite) begin
            pc_next    = pc_plus4;
            instr_next = NOP;
            pc4_next   = '0;
            valid_next = 1'b0;
        end else begin
            pc_next    = pc_plus4;
            instr_next = Instr_in;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC           <= RESET_PC;
            IF_ID_Instr  <= '0;
            IF_ID_PC4    <= '0;
            IF_ID_Valid  <= 1'b0;
            CtrlBubble   <= 1'b0;
            StallCount   <= '0;
            StallTimeout <= 1'b0;
            hold_run     <= '0;
        end else begin
            PC           <= pc_next;
            IF_ID_Instr  <= instr_next;
            IF_ID_PC4    <= pc4_next;
            IF_ID_Valid  <= valid_next;
            CtrlBubble   <= CtrlWrite;
            StallCount   <= stall_cnt_next;
            StallTimeout <= timeout_next;
            hold_run     <= hold_run_next;
        end
    end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, IF_IDWrite, CtrlWrite, RedirectValid;
    logic [31:0] RedirectTarget, Instr_in;
    logic [31:0] PC, IF_ID_Instr, IF_ID_PC4;
    logic        IF_ID_Valid, CtrlBubble, StallTimeout;
    logic [15:0] StallCount;

    int n_cmp = 0;
    int n_err = 0;

    if_stage_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .PCWrite        (PCWrite),
        .IF_IDWrite     (IF_IDWrite),
        .CtrlWrite      (CtrlWrite),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .Instr_in       (Instr_in),
        .PC             (PC),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_PC4      (IF_ID_PC4),
        .IF_ID_Valid    (IF_ID_Valid),
        .CtrlBubble     (CtrlBubble),
        .StallCount     (StallCount),
        .StallTimeout   (StallTimeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic cw,
                         input logic rv, input logic [31:0] tgt, input logic [31:0] ins);
        PCWrite        = pw;
        IF_IDWrite     = iw;
        CtrlWrite      = cw;
        RedirectValid  = rv;
        RedirectTarget = tgt;
        Instr_in       = ins;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    PC, 32'h0040_0000);
        chk({tag, "_instr"}, IF_ID_Instr, 32'h0);
        chk({tag, "_pc4"},   IF_ID_PC4, 32'h0);
        chk({tag, "_valid"}, 32'(IF_ID_Valid), 32'd0);
        chk({tag, "_bub"},   32'(CtrlBubble), 32'd0);
        chk({tag, "_cnt"},   32'(StallCount), 32'd0);
        chk({tag, "_tmo"},   32'(StallTimeout), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #2;
        chk_reset_vals("rst");
        chk("rst_fsm", 32'(dut.state), 32'd0);
        step();
        step();
        reset = 1'b0;

        // Three straight-line fetches
        drive(0, 0, 0, 0, 32'h0, 32'h2008_0005);
        step();
        chk("adv1_pc", PC, 32'h0040_0004);
        chk("adv1_pc4", IF_ID_PC4, 32'h0040_0004);
        chk("adv1_instr", IF_ID_Instr, 32'h2008_0005);
        chk("adv1_valid", 32'(IF_ID_Valid), 32'd1);
        step();
        chk("adv2_pc", PC, 32'h0040_0008);
        chk("adv2_pc4", IF_ID_PC4, 32'h0040_0008);

        // Load-use hold for one cycle
        drive(1, 1, 1, 0, 32'h0, 32'h1111_1111);
        step();
        chk("lu_pc", PC, 32'h0040_0008);
        chk("lu_pc4", IF_ID_PC4, 32'h0040_0008);
        chk("lu_instr", IF_ID_Instr, 32'h2008_0005);
        chk("lu_valid", 32'(IF_ID_Valid), 32'd1);
        chk("lu_bub", 32'(CtrlBubble), 32'd1);
        chk("lu_cnt", 32'(StallCount), 32'd1);
        chk("lu_fsm", 32'(dut.state), 32'd1);
        drive(0, 0, 0, 0, 32'h0, 32'h2008_0005);
        step();
        chk("lu2_pc", PC, 32'h0040_000C);
        chk("lu2_bub", 32'(CtrlBubble), 32'd0);
        chk("lu2_fsm", 32'(dut.state), 32'd0);

        // Branch redirect with misaligned target
        drive(0, 1, 0, 1, 32'h0040_0103, 32'h2222_2222);
        step();
        chk("br_pc", PC, 32'h0040_0100);
        chk("br_valid", 32'(IF_ID_Valid), 32'd0);
        chk("br_instr", IF_ID_Instr, 32'h0);
        chk("br_fsm", 32'(dut.state), 32'd2);
        drive(0, 0, 0, 0, 32'h0, 32'hAABB_CCDD);
        step();
        chk("sq_pc", PC, 32'h0040_0104);
        chk("sq_instr", IF_ID_Instr, 32'hAABB_CCDD);
        chk("sq_pc4", IF_ID_PC4, 32'h0040_0104);
        chk("sq_valid", 32'(IF_ID_Valid), 32'd1);
        chk("sq_fsm", 32'(dut.state), 32'd0);

        // JR-style: advance while requesting a control bubble
        drive(0, 0, 1, 0, 32'h0, 32'h0323_0008);
        step();
        chk("jr_pc", PC, 32'h0040_0108);
        chk("jr_instr", IF_ID_Instr, 32'h0323_0008);
        chk("jr_bub", 32'(CtrlBubble), 32'd1);

        // Flush without redirect
        drive(0, 1, 0, 0, 32'h0, 32'h3333_3333);
        step();
        chk("fl_pc", PC, 32'h0040_010C);
        chk("fl_valid", 32'(IF_ID_Valid), 32'd0);
        chk("fl_bub", 32'(CtrlBubble), 32'd0);

        // PC held with IF/ID flush; redirect under PCWrite ignored
        drive(1, 0, 0, 1, 32'h0000_1000, 32'h4444_4444);
        step();
        chk("fz_pc", PC, 32'h0040_010C);
        chk("fz_instr", IF_ID_Instr, 32'h0);
        chk("fz_valid", 32'(IF_ID_Valid), 32'd0);
        chk("fz_cnt", 32'(StallCount), 32'd1);
        chk("fz_fsm", 32'(dut.state), 32'd0);

        // Redirect to top of address space, then wrap
        drive(0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0);
        step();
        chk("top_pc", PC, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0, 32'h5555_5555);
        step();
        chk("wrap_pc", PC, 32'h0000_0000);
        chk("wrap_pc4", IF_ID_PC4, 32'h0000_0000);
        chk("wrap_valid", 32'(IF_ID_Valid), 32'd1);

        // Hold-run counter clears when the hold breaks
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(1, 1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        drive(1, 1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        chk("run_clr_tmo", 32'(StallTimeout), 32'd0);
        chk("run_clr_cnt", 32'(StallCount), 32'd20);
        for (int i = 0; i < 6; i++) step();
        chk("run_16_tmo", 32'(StallTimeout), 32'd1);

        // Watchdog from reset: exactly 16 hold edges
        reset = 1'b1;
        #1;
        chk("rst2_tmo", 32'(StallTimeout), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("to15_tmo", 32'(StallTimeout), 32'd0);
        chk("to15_cnt", 32'(StallCount), 32'd15);
        chk("to15_pc", PC, 32'h0040_0000);
        step();
        chk("to16_tmo", 32'(StallTimeout), 32'd1);
        chk("to16_cnt", 32'(StallCount), 32'd16);
        drive(0, 0, 0, 0, 32'h0, 32'h6666_6666);
        step();
        chk("tor_tmo", 32'(StallTimeout), 32'd1);
        chk("tor_cnt", 32'(StallCount), 32'd16);
        chk("tor_pc", PC, 32'h0040_0004);

        // Async reset in the middle of a hold at PC 0x00400040
        for (int i = 0; i < 15; i++) step();
        chk("pre_pc", PC, 32'h0040_0040);
        drive(1, 1, 1, 0, 32'h0, 32'h0);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        chk("arst_fsm", 32'(dut.state), 32'd0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h7777_7777);
        step();
        chk("post_pc", PC, 32'h0040_0004);
        chk("post_pc4", IF_ID_PC4, 32'h0040_0004);
        chk("post_instr", IF_ID_Instr, 32'h7777_7777);
        chk("post_valid", 32'(IF_ID_Valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
